// File: rtl/mesi_coherence_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mesi_coherence_ctrl
// Description : MESI coherence controller for the last-level cache. Keeps a
//               SETS x WAYS array of 2-bit line states and serialises CPU
//               requests, bus snoops and evictions through a four-state FSM
//               (IDLE -> EVAL -> [BUS ->] RESP -> IDLE). Bus transactions use
//               a valid/ack handshake.
// Ports       :
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   req_valid/req_ready, req_cmd, req_set, req_way, req_hit  request channel
//   bus_valid, bus_op, bus_ack, bus_shared                   bus channel
//   rsp_valid, rsp_state, snoop_result, rsp_flush            response pulse
//   protocol_err   sticky error flag (illegal snoop / reserved command)
// Revision    : 1.0 - initial release
// ============================================================================
module mesi_coherence_ctrl #(
    parameter int SETS  = 16,
    parameter int WAYS  = 4,
    parameter int SET_W = $clog2(SETS),
    parameter int WAY_W = (WAYS > 1 ? $clog2(WAYS) : 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [SET_W-1:0] req_set,
    input  logic [WAY_W-1:0] req_way,
    input  logic             req_hit,
    output logic             bus_valid,
    output logic [1:0]       bus_op,
    input  logic             bus_ack,
    input  logic             bus_shared,
    output logic             rsp_valid,
    output logic [1:0]       rsp_state,
    output logic [1:0]       snoop_result,
    output logic             rsp_flush,
    output logic             protocol_err
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_BUS  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Line states
    localparam logic [1:0] C_M = 2'd0;
    localparam logic [1:0] C_E = 2'd1;
    localparam logic [1:0] C_S = 2'd2;
    localparam logic [1:0] C_I = 2'd3;

    // Commands
    localparam logic [2:0] C_CPU_RD   = 3'd0;
    localparam logic [2:0] C_CPU_WR   = 3'd1;
    localparam logic [2:0] C_SNP_RD   = 3'd2;
    localparam logic [2:0] C_SNP_RDX  = 3'd3;
    localparam logic [2:0] C_SNP_UPGR = 3'd4;
    localparam logic [2:0] C_EVICT    = 3'd5;

    // Bus operations
    localparam logic [1:0] C_BUSRD   = 2'd0;
    localparam logic [1:0] C_BUSRDX  = 2'd1;
    localparam logic [1:0] C_BUSUPGR = 2'd2;
    localparam logic [1:0] C_FLUSH   = 2'd3;

    // Snoop results
    localparam logic [1:0] C_NOHIT = 2'd0;
    localparam logic [1:0] C_HIT   = 2'd1;
    localparam logic [1:0] C_HITM  = 2'd2;

    logic [1:0]       state_q;
    logic [2:0]       cmd_q;
    logic [SET_W-1:0] set_q;
    logic [WAY_W-1:0] way_q;
    logic             hit_q;
    logic [1:0]       rsp_state_q;
    logic [1:0]       snoop_q;
    logic             flush_q;
    logic             we_q;
    logic [1:0]       op_q;
    logic             err_q;
    logic [1:0]       mesi_q [SETS][WAYS];

    // Decision made in EVAL
    logic [1:0] eff_d;
    logic [1:0] nxt_d;
    logic [1:0] snoop_d;
    logic [1:0] op_d;
    logic       flush_d;
    logic       we_d;
    logic       bus_d;
    logic       err_d;

    // Array write port
    logic       wr_en_d;
    logic [1:0] wr_val_d;

    always_comb begin
        eff_d   = req_hit_line();
        nxt_d   = eff_d;
        snoop_d = C_NOHIT;
        op_d    = C_BUSRD;
        flush_d = 1'b0;
        we_d    = 1'b0;
        bus_d   = 1'b0;
        err_d   = 1'b0;
        case (cmd_q)
            C_CPU_RD: begin
                if (eff_d == C_I) begin
                    // Final E/S is resolved from bus_shared at ack time
                    bus_d = 1'b1;
                    op_d  = C_BUSRD;
                    nxt_d = C_E;
                    we_d  = 1'b1;
                end
            end
            C_CPU_WR: begin
                nxt_d = C_M;
                we_d  = (eff_d != C_M);
                if (eff_d == C_S) begin
                    bus_d = 1'b1;
                    op_d  = C_BUSUPGR;
                end else if (eff_d == C_I) begin
                    bus_d = 1'b1;
                    op_d  = C_BUSRDX;
                end
            end
            C_SNP_RD, C_SNP_RDX: begin
                if (eff_d != C_I) begin
                    nxt_d   = (cmd_q == C_SNP_RD) ? C_S : C_I;
                    we_d    = 1'b1;
                    snoop_d = (eff_d == C_M) ? C_HITM : C_HIT;
                    flush_d = (eff_d == C_M);
                end
            end
            C_SNP_UPGR: begin
                if (eff_d == C_S) begin
                    nxt_d   = C_I;
                    we_d    = 1'b1;
                    snoop_d = C_HIT;
                end else if (eff_d != C_I) begin
                    // Another cache upgrading while we hold E/M is illegal
                    err_d = 1'b1;
                end
            end
            C_EVICT: begin
                if (eff_d != C_I) begin
                    nxt_d = C_I;
                    we_d  = 1'b1;
                    if (eff_d == C_M) begin
                        bus_d   = 1'b1;
                        op_d    = C_FLUSH;
                        flush_d = 1'b1;
                    end
                end
            end
            default: begin
                nxt_d = C_I;
                err_d = 1'b1;
            end
        endcase
    end

    // Effective state: a tag miss is treated as Invalid regardless of the
    // stale contents of the victim way.
    function automatic logic [1:0] req_hit_line();
        return hit_q ? mesi_q[set_q][way_q] : C_I;
    endfunction

    always_comb begin
        wr_en_d  = 1'b0;
        wr_val_d = nxt_d;
        if (state_q == ST_EVAL) begin
            wr_en_d  = we_d & ~bus_d;
            wr_val_d = nxt_d;
        end else if (state_q == ST_BUS) begin
            wr_en_d  = we_q & bus_ack;
            wr_val_d = (cmd_q == C_CPU_RD) ? (bus_shared ? C_S : C_E) : rsp_state_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    mesi_q[s][w] <= C_I;
                end
            end
        end else if (wr_en_d) begin
            mesi_q[set_q][way_q] <= wr_val_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 3'd0;
            set_q       <= '0;
            way_q       <= '0;
            hit_q       <= 1'b0;
            rsp_state_q <= C_I;
            snoop_q     <= C_NOHIT;
            flush_q     <= 1'b0;
            we_q        <= 1'b0;
            op_q        <= C_BUSRD;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        cmd_q   <= req_cmd;
                        set_q   <= req_set;
                        way_q   <= req_way;
                        hit_q   <= req_hit;
                        state_q <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    rsp_state_q <= nxt_d;
                    snoop_q     <= snoop_d;
                    flush_q     <= flush_d;
                    we_q        <= we_d;
                    op_q        <= op_d;
                    err_q       <= err_q | err_d;
                    state_q     <= bus_d ? ST_BUS : ST_RESP;
                end
                ST_BUS: begin
                    if (bus_ack) begin
                        if (cmd_q == C_CPU_RD) begin
                            rsp_state_q <= bus_shared ? C_S : C_E;
                        end
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign bus_valid    = (state_q == ST_BUS);
    assign bus_op       = bus_valid ? op_q : C_BUSRD;
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_state    = rsp_valid ? rsp_state_q : C_I;
    assign snoop_result = rsp_valid ? snoop_q : C_NOHIT;
    assign rsp_flush    = rsp_valid & flush_q;
    assign protocol_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mesi_coherence_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesi_coherence_ctrl
// Description : Directed self-checking bench for mesi_coherence_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesi_coherence_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_cmd;
    logic [3:0] req_set;
    logic [1:0] req_way;
    logic       req_hit;
    logic       bus_valid;
    logic [1:0] bus_op;
    logic       bus_ack;
    logic       bus_shared;
    logic       rsp_valid;
    logic [1:0] rsp_state;
    logic [1:0] snoop_result;
    logic       rsp_flush;
    logic       protocol_err;

    int n_vec = 0;
    int n_err = 0;

    mesi_coherence_ctrl #(.SETS(16), .WAYS(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_set      (req_set),
        .req_way      (req_way),
        .req_hit      (req_hit),
        .bus_valid    (bus_valid),
        .bus_op       (bus_op),
        .bus_ack      (bus_ack),
        .bus_shared   (bus_shared),
        .rsp_valid    (rsp_valid),
        .rsp_state    (rsp_state),
        .snoop_result (snoop_result),
        .rsp_flush    (rsp_flush),
        .protocol_err (protocol_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".ready"}, {7'd0, req_ready},    8'd1);
        chk({tag, ".bvld"},  {7'd0, bus_valid},    8'd0);
        chk({tag, ".bop"},   {6'd0, bus_op},       8'd0);
        chk({tag, ".rvld"},  {7'd0, rsp_valid},    8'd0);
        chk({tag, ".rst"},   {6'd0, rsp_state},    8'd3);
        chk({tag, ".snp"},   {6'd0, snoop_result}, 8'd0);
        chk({tag, ".fl"},    {7'd0, rsp_flush},    8'd0);
        chk({tag, ".err"},   {7'd0, protocol_err}, 8'd0);
    endtask

    // One full transaction; expectations are hand-derived MESI results.
    task automatic do_req(input string tag, input logic [2:0] cmd, input logic [3:0] set,
                          input logic [1:0] way, input logic hit, input logic exp_bus,
                          input logic [1:0] exp_op, input int delay, input logic shared,
                          input logic [1:0] exp_state, input logic [1:0] exp_snp,
                          input logic exp_flush);
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_set   = set;
        req_way   = way;
        req_hit   = hit;
        @(posedge clk);
        #1;
        // Scramble fields: the DUT must have registered them
        req_valid = 1'b0;
        req_cmd   = 3'd7;
        req_set   = ~set;
        req_way   = ~way;
        req_hit   = ~hit;
        chk({tag, ".eval_rdy"}, {7'd0, req_ready}, 8'd0);
        chk({tag, ".eval_bv"},  {7'd0, bus_valid}, 8'd0);
        chk({tag, ".eval_rv"},  {7'd0, rsp_valid}, 8'd0);
        @(posedge clk);
        #1;
        if (exp_bus) begin
            for (int i = 0; i <= delay; i++) begin
                chk({tag, ".bv"},  {7'd0, bus_valid}, 8'd1);
                chk({tag, ".op"},  {6'd0, bus_op},    {6'd0, exp_op});
                chk({tag, ".brv"}, {7'd0, rsp_valid}, 8'd0);
                if (i < delay) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus_ack    = 1'b1;
            bus_shared = shared;
            @(posedge clk);
            #1;
            bus_ack    = 1'b0;
            bus_shared = 1'b0;
            chk({tag, ".bv_drop"}, {7'd0, bus_valid}, 8'd0);
        end
        chk({tag, ".rv"},    {7'd0, rsp_valid},    8'd1);
        chk({tag, ".state"}, {6'd0, rsp_state},    {6'd0, exp_state});
        chk({tag, ".snoop"}, {6'd0, snoop_result}, {6'd0, exp_snp});
        chk({tag, ".flush"}, {7'd0, rsp_flush},    {7'd0, exp_flush});
        @(posedge clk);
        #1;
        chk({tag, ".rv_end"},  {7'd0, rsp_valid}, 8'd0);
        chk({tag, ".rdy_end"}, {7'd0, req_ready}, 8'd1);
        chk({tag, ".st_idle"}, {6'd0, rsp_state}, 8'd3);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_cmd    = 3'd0;
        req_set    = 4'd0;
        req_way    = 2'd0;
        req_hit    = 1'b0;
        bus_ack    = 1'b0;
        bus_shared = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");

        //     tag       cmd   set   way  hit  bus  op   dly sh   state snp  fl
        do_req("rd_miss", 3'd0, 4'd3, 2'd1, 1'b0, 1'b1, 2'd0, 0, 1'b0, 2'd1, 2'd0, 1'b0);
        do_req("rd_hit",  3'd0, 4'd3, 2'd1, 1'b1, 1'b0, 2'd0, 0, 1'b0, 2'd1, 2'd0, 1'b0);
        do_req("wr_e",    3'd1, 4'd3, 2'd1, 1'b1, 1'b0, 2'd0, 0, 1'b0, 2'd0, 2'd0, 1'b0);
        do_req("snprd_m", 3'd2, 4'd3, 2'd1, 1'b1, 1'b0, 2'd0, 0, 1'b0, 2'd2, 2'd2, 1'b1);
        do_req("wr_s",    3'd1, 4'd3, 2'd1, 1'b1, 1'b1, 2'd2, 0, 1'b0, 2'd0, 2'd0, 1'b0);
        do_req("rd_shr",  3'd0, 4'd5, 2'd2, 1'b0, 1'b1, 2'd0, 5, 1'b1, 2'd2, 2'd0, 1'b0);
        do_req("rdx_s",   3'd3, 4'd5, 2'd2, 1'b1, 1'b0, 2'd0, 0, 1'b0, 2'd3, 2'd1, 1'b0);
        do_req("evict_m", 3'd5, 4'd3, 2'd1, 1'b1, 1'b1, 2'd3, 0, 1'b0, 2'd3, 2'd0, 1'b1);
        do_req("snp_inv", 3'd2, 4'd3, 2'd1, 1'b1, 1'b0, 2'd0, 0, 1'b0, 2'd3, 2'd0, 1'b0);
        chk("err_clear", {7'd0, protocol_err}, 8'd0);
        do_req("rd_e7",   3'd0, 4'd7, 2'd0, 1'b0, 1'b1, 2'd0, 0, 1'b0, 2'd1, 2'd0, 1'b0);
        do_req("upgr_e",  3'd4, 4'd7, 2'd0, 1'b1, 1'b0, 2'd0, 0, 1'b0, 2'd1, 2'd0, 1'b0);
        chk("err_set", {7'd0, protocol_err}, 8'd1);
        do_req("rd_e7b",  3'd0, 4'd7, 2'd0, 1'b1, 1'b0, 2'd0, 0, 1'b0, 2'd1, 2'd0, 1'b0);
        do_req("resvd",   3'd6, 4'd7, 2'd0, 1'b1, 1'b0, 2'd0, 0, 1'b0, 2'd3, 2'd0, 1'b0);
        do_req("rd_e7c",  3'd0, 4'd7, 2'd0, 1'b1, 1'b0, 2'd0, 0, 1'b0, 2'd1, 2'd0, 1'b0);
        chk("err_sticky", {7'd0, protocol_err}, 8'd1);

        // Reset in the middle of a BusRdX
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = 3'd1;
        req_set   = 4'd9;
        req_way   = 2'd0;
        req_hit   = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.bv", {7'd0, bus_valid}, 8'd1);
        chk("mid.op", {6'd0, bus_op},    8'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst.rv", {7'd0, rsp_valid}, 8'd0);
            chk("post_rst.bv", {7'd0, bus_valid}, 8'd0);
        end
        // Line never installed: a hit lookup still sees I and must refetch
        do_req("rd_after", 3'd0, 4'd9, 2'd0, 1'b1, 1'b1, 2'd0, 0, 1'b0, 2'd1, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
